// File: rtl/dwc_ddrphy_zcal_seq.sv
// Impedance-calibration sequencer: MSB-first SAR searches for the PU driver code,
// the PD driver code and the comparator DAC code, one comparator sample per trial bit.
module dwc_ddrphy_zcal_seq #(
    parameter int CODE_W   = 5,
    parameter int DAC_W    = 8,
    parameter int SETTLE_W = 16
) (
    input  logic                DfiClk,
    input  logic                Reset,
    input  logic                CalStart,
    input  logic [SETTLE_W-1:0] csrCalSettle,
    input  logic                csrCmpInvertCalDrvPu50,
    input  logic                csrCmpInvertCalDrvPd50,
    input  logic                csrCmpInvertCalDac50,
    input  logic                CmpOut,
    output logic                CalExt_VIO,
    output logic                CalInt_VIO,
    output logic                CalCmpr_VIO,
    output logic [CODE_W-1:0]   calDrvPU,
    output logic [CODE_W-1:0]   calDrvPD,
    output logic [DAC_W-1:0]    CalDac,
    output logic                CalBusy,
    output logic                CalDone
);

    localparam int MAX_W = (DAC_W > CODE_W) ? DAC_W : CODE_W;
    localparam int BIT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [2:0] {S_IDLE, S_TRIAL, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    typedef enum logic [1:0] {PH_PU, PH_PD, PH_DAC} phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0]   pu_q, pu_d;
    logic [CODE_W-1:0]   pd_q, pd_d;
    logic [DAC_W-1:0]    dac_q, dac_d;
    logic [2:0]          sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cmp_meta_q, cmp_s_q;

    logic                inv;
    logic                n_above;
    logic [SETTLE_W-1:0] settle_eff;
    logic [CODE_W-1:0]   code_mask;
    logic [DAC_W-1:0]    dac_mask;

    always_ff @(posedge DfiClk or posedge Reset) begin
        if (Reset) begin
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cmp_meta_q <= CmpOut;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    always_comb begin
        case (phase_q)
            PH_PU:   inv = csrCmpInvertCalDrvPu50;
            PH_PD:   inv = csrCmpInvertCalDrvPd50;
            PH_DAC:  inv = csrCmpInvertCalDac50;
            default: inv = 1'b0;
        endcase
    end

    assign n_above    = cmp_s_q ^ inv;
    assign settle_eff = (csrCalSettle == '0) ? SETTLE_W'(1) : csrCalSettle;
    assign code_mask  = CODE_W'(1) << bit_q;
    assign dac_mask   = DAC_W'(1) << bit_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        pu_d    = pu_q;
        pd_d    = pd_q;
        dac_d   = dac_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CalStart) begin
                    state_d = S_TRIAL;
                    phase_d = PH_PU;
                    bit_d   = BIT_W'(CODE_W - 1);
                    pu_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            S_TRIAL: begin
                case (phase_q)
                    PH_PU: begin
                        pu_d  = pu_q | code_mask;
                        sel_d = 3'b100;
                    end
                    PH_PD: begin
                        pd_d  = pd_q | code_mask;
                        sel_d = 3'b010;
                    end
                    default: begin
                        dac_d = dac_q | dac_mask;
                        sel_d = 3'b001;
                    end
                endcase
                cnt_d   = settle_eff;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q <= SETTLE_W'(1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            S_SAMPLE: begin
                // Trial code above target: drop the bit under test.
                if (n_above) begin
                    case (phase_q)
                        PH_PU:   pu_d  = pu_q & ~code_mask;
                        PH_PD:   pd_d  = pd_q & ~code_mask;
                        default: dac_d = dac_q & ~dac_mask;
                    endcase
                end
                if (bit_q != '0) begin
                    bit_d   = bit_q - BIT_W'(1);
                    state_d = S_TRIAL;
                end else begin
                    case (phase_q)
                        PH_PU: begin
                            phase_d = PH_PD;
                            bit_d   = BIT_W'(CODE_W - 1);
                            pd_d    = '0;
                            state_d = S_TRIAL;
                        end
                        PH_PD: begin
                            phase_d = PH_DAC;
                            bit_d   = BIT_W'(DAC_W - 1);
                            dac_d   = '0;
                            state_d = S_TRIAL;
                        end
                        default: begin
                            sel_d   = 3'b000;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge DfiClk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            phase_q <= PH_PU;
            bit_q   <= '0;
            cnt_q   <= '0;
            pu_q    <= '0;
            pd_q    <= '0;
            dac_q   <= '0;
            sel_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
            dac_q   <= dac_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign CalExt_VIO  = sel_q[2];
    assign CalInt_VIO  = sel_q[1];
    assign CalCmpr_VIO = sel_q[0];
    assign calDrvPU    = pu_q;
    assign calDrvPD    = pd_q;
    assign CalDac      = dac_q;
    assign CalBusy     = busy_q;
    assign CalDone     = done_q;

endmodule

// File: tb/tb_dwc_ddrphy_zcal_seq.sv
// Bench for dwc_ddrphy_zcal_seq: an analog comparator model plus a SAR reference
// that computes each expected code from the target and polarity settings.
module tb_dwc_ddrphy_zcal_seq;

    localparam int CODE_W   = 5;
    localparam int DAC_W    = 8;
    localparam int SETTLE_W = 16;

    logic                DfiClk = 1'b0;
    logic                Reset;
    logic                CalStart;
    logic [SETTLE_W-1:0] csrCalSettle;
    logic                CmpOut;
    logic                CalExt_VIO, CalInt_VIO, CalCmpr_VIO;
    logic [CODE_W-1:0]   calDrvPU, calDrvPD;
    logic [DAC_W-1:0]    CalDac;
    logic                CalBusy, CalDone;

    logic [2:0] dut_inv;
    logic [2:0] b_inv;
    bit         force_above;
    int         t_pu, t_pd, t_dac;
    int         passed = 0;
    int         total  = 0;
    int         done_cnt = 0;
    int         oh_err = 0;

    dwc_ddrphy_zcal_seq #(.CODE_W(CODE_W), .DAC_W(DAC_W), .SETTLE_W(SETTLE_W)) dut (
        .DfiClk                 (DfiClk),
        .Reset                  (Reset),
        .CalStart               (CalStart),
        .csrCalSettle           (csrCalSettle),
        .csrCmpInvertCalDrvPu50 (dut_inv[0]),
        .csrCmpInvertCalDrvPd50 (dut_inv[1]),
        .csrCmpInvertCalDac50   (dut_inv[2]),
        .CmpOut                 (CmpOut),
        .CalExt_VIO             (CalExt_VIO),
        .CalInt_VIO             (CalInt_VIO),
        .CalCmpr_VIO            (CalCmpr_VIO),
        .calDrvPU               (calDrvPU),
        .calDrvPD               (calDrvPD),
        .CalDac                 (CalDac),
        .CalBusy                (CalBusy),
        .CalDone                (CalDone)
    );

    always #5 DfiClk = ~DfiClk;

    // Comparator: reports "above" when the selected code exceeds its target.
    always_comb begin
        CmpOut = 1'b0;
        if (CalExt_VIO)
            CmpOut = b_inv[0] ^ (force_above || (int'(calDrvPU) > t_pu));
        else if (CalInt_VIO)
            CmpOut = b_inv[1] ^ (force_above || (int'(calDrvPD) > t_pd));
        else if (CalCmpr_VIO)
            CmpOut = b_inv[2] ^ (force_above || (int'(CalDac) > t_dac));
    end

    always @(negedge DfiClk) begin
        if (CalDone) done_cnt++;
        if (!$onehot0({CalExt_VIO, CalInt_VIO, CalCmpr_VIO})) oh_err++;
    end

    // Largest code whose trial the normalized comparator does not flag as above.
    function automatic int sar(input int width, input int target, input bit mism, input bit fa);
        int code;
        code = 0;
        for (int b = width - 1; b >= 0; b--) begin
            int  trial;
            bit  above;
            trial = code | (1 << b);
            above = fa ? 1'b1 : (mism ^ (trial > target));
            if (!above) code = trial;
        end
        return code;
    endfunction

    function automatic int run_len(input int settle);
        int n;
        n = (settle < 1) ? 1 : settle;
        return (2 * CODE_W + DAC_W) * (n + 2) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_run(input bit hold, input bit chg, output int busy,
                          output int seq, output int sel_done, output bit tmo);
        int last_nz;
        int cur;
        busy = 0; seq = 0; sel_done = -1; tmo = 1'b1; last_nz = 0;
        @(negedge DfiClk);
        CalStart = 1'b1;
        @(negedge DfiClk);
        if (!hold) CalStart = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            cur = int'({CalExt_VIO, CalInt_VIO, CalCmpr_VIO});
            if (CalBusy) busy++;
            if (cur != 0 && cur != last_nz) begin
                seq = (seq << 4) | cur;
                last_nz = cur;
            end
            if (chg && CalCmpr_VIO && csrCalSettle != 16'd8) csrCalSettle = 16'd8;
            if (CalDone) begin
                sel_done = cur;
                tmo = 1'b0;
                break;
            end
            @(negedge DfiClk);
        end
    endtask

    task automatic chk_codes(input string tag);
        chk({tag, " pu"},  32'(calDrvPU), sar(CODE_W, t_pu,  dut_inv[0] ^ b_inv[0], force_above));
        chk({tag, " pd"},  32'(calDrvPD), sar(CODE_W, t_pd,  dut_inv[1] ^ b_inv[1], force_above));
        chk({tag, " dac"}, 32'(CalDac),   sar(DAC_W,  t_dac, dut_inv[2] ^ b_inv[2], force_above));
    endtask

    task automatic run_chk(input string tag, input int exp_busy, input bit chg);
        int busy, seq, sd;
        bit tmo;
        do_run(1'b0, chg, busy, seq, sd, tmo);
        chk({tag, " timeout"}, 32'(tmo), 32'd0);
        chk_codes(tag);
        chk({tag, " cycles"}, busy, exp_busy);
        chk({tag, " sel order"}, seq, 32'h421);
        chk({tag, " sel at done"}, sd, 32'd0);
    endtask

    initial begin
        int busy, seq, sd, d0, s;
        bit tmo;

        Reset = 1'b1; CalStart = 1'b0; csrCalSettle = 16'd4;
        dut_inv = 3'b000; b_inv = 3'b000; force_above = 1'b0;
        t_pu = 12; t_pd = 10; t_dac = 11;
        repeat (3) @(negedge DfiClk);
        chk("reset outputs", 32'({CalExt_VIO, CalInt_VIO, CalCmpr_VIO, calDrvPU, calDrvPD,
                                  CalDac, CalBusy, CalDone}), 32'd0);
        Reset = 1'b0;
        @(negedge DfiClk);

        run_chk("basic", 109, 1'b0);
        chk("basic pu literal", 32'(calDrvPU), 32'd12);

        dut_inv = 3'b111; b_inv = 3'b111;
        run_chk("inv matched", 109, 1'b0);

        b_inv = 3'b000;
        run_chk("inv mismatched", 109, 1'b0);
        chk("mismatched pu literal", 32'(calDrvPU), 32'd31);

        dut_inv = 3'b000;
        t_pu = 31; t_pd = 31; t_dac = 255; csrCalSettle = 16'd0;
        run_chk("full scale settle0", run_len(0), 1'b0);
        csrCalSettle = 16'd1;
        run_chk("full scale settle1", run_len(1), 1'b0);

        force_above = 1'b1; csrCalSettle = 16'd4;
        run_chk("forced above", 109, 1'b0);
        chk("forced above dac literal", 32'(CalDac), 32'd0);
        force_above = 1'b0;

        for (int r = 0; r < 4; r++) begin
            t_pu  = int'($urandom_range(0, 40));
            t_pd  = int'($urandom_range(0, 40));
            t_dac = int'($urandom_range(0, 300));
            dut_inv = 3'($urandom_range(0, 7));
            b_inv   = 3'($urandom_range(0, 7));
            s = int'($urandom_range(3, 7));
            csrCalSettle = 16'(s);
            run_chk("random", run_len(s), 1'b0);
        end

        dut_inv = 3'b000; b_inv = 3'b000;
        t_pu = int'($urandom_range(0, 31)); t_pd = int'($urandom_range(0, 31));
        t_dac = int'($urandom_range(0, 255));
        csrCalSettle = 16'd4;
        run_chk("settle change", 10 * 6 + 6 + 7 * 10 + 1, 1'b1);

        t_pu = 12; t_pd = 10; t_dac = 11; csrCalSettle = 16'd4;
        @(negedge DfiClk);
        CalStart = 1'b1;
        @(negedge DfiClk);
        CalStart = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (CalInt_VIO) begin
                tmo = 1'b0;
                break;
            end
            @(negedge DfiClk);
        end
        chk("reach pd phase", 32'(tmo), 32'd0);
        repeat (3) @(negedge DfiClk);
        d0 = done_cnt;
        #2 Reset = 1'b1;
        #1 chk("async reset outputs", 32'({CalExt_VIO, CalInt_VIO, CalCmpr_VIO, calDrvPU,
                                          calDrvPD, CalDac, CalBusy, CalDone}), 32'd0);
        repeat (2) @(negedge DfiClk);
        Reset = 1'b0;
        repeat (30) @(negedge DfiClk);
        chk("no done after abort", done_cnt, d0);
        chk("idle after abort", 32'(CalBusy), 32'd0);
        run_chk("after reset", 109, 1'b0);

        do_run(1'b1, 1'b0, busy, seq, sd, tmo);
        chk("hold timeout", 32'(tmo), 32'd0);
        chk_codes("hold");
        chk("hold cycles", busy, 109);
        @(negedge DfiClk);
        chk("hold idle gap", 32'(CalBusy), 32'd0);
        @(negedge DfiClk);
        chk("hold restart", 32'(CalBusy), 32'd1);
        CalStart = 1'b0;
        repeat (20) @(negedge DfiClk);
        CalStart = 1'b1;
        @(negedge DfiClk);
        CalStart = 1'b0;
        d0 = done_cnt;
        tmo = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge DfiClk);
            if (CalDone) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("restart timeout", 32'(tmo), 32'd0);
        chk_codes("restart");
        repeat (5) @(negedge DfiClk);
        chk("busy pulse ignored", 32'(CalBusy), 32'd0);
        chk("single done", done_cnt, d0 + 1);

        chk("select one-hot", oh_err, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
